mem_access_stage: RTL

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_pkg.sv | 57 +++++
 rtl/load_formatter.sv | 61 ++++++
 rtl/mem_access_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
//
// Shared definitions for the data-memory access stage:
//   - access size encodings carried on size_in
//   - the two-state access FSM encoding
//   - the default bus-error timeout
//   - helpers that build store byte enables and replicated store data
//
// Optional feature macro used by the stage: MEM_ALIGN_CHECK_EN
// ---------------------------------------------------------------------------
package mem_pkg;

   // Default number of BUSY cycles spent waiting for dmem_ack.
   localparam int MAX_WAIT_DEFAULT = 15;

   // Access size as encoded on size_in.
   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } size_t;

   // Access FSM states.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Byte enables for a store. Halves only look at addr[1], so an odd
   // half address is folded onto the enclosing aligned half. The reserved
   // size encoding behaves like a word.
   function automatic logic [3:0] store_byte_enable(input logic [1:0] size,
                                                    input logic [1:0] addr_lsb);
      logic [3:0] be;
      case (size)
         SIZE_BYTE: be = 4'b0001 << addr_lsb;
         SIZE_HALF: be = 4'b0011 << {addr_lsb[1], 1'b0};
         default:   be = 4'b1111;
      endcase
      return be;
   endfunction

   // Store data replicated across all byte lanes so the memory only has
   // to honour the byte enables.
   function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                               input logic [31:0] data);
      logic [31:0] lanes;
      case (size)
         SIZE_BYTE: lanes = {4{data[7:0]}};
         SIZE_HALF: lanes = {2{data[15:0]}};
         default:   lanes = data;
      endcase
      return lanes;
   endfunction

endpackage

// File: rtl/load_formatter.sv
// ---------------------------------------------------------------------------
// load_formatter
//
// Purely combinational load data formatter. Picks the little-endian lane
// addressed by addr_lsb out of the raw memory word and sign- or
// zero-extends it to 32 bits.
//
// Ports:
//   rdata       in  32  raw word returned by data memory
//   addr_lsb    in   2  low address bits of the access
//   size        in   2  access size (mem_pkg::size_t encoding)
//   is_unsigned in   1  1 = zero-extend, 0 = sign-extend
//   data_out    out 32  formatted load value
// ---------------------------------------------------------------------------
module load_formatter
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lsb,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] data_out
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic        sign_bit;

   // Lane selection: bytes use both address bits, halves only addr[1].
   always_comb begin
      byte_lane = rdata[7:0];
      case (addr_lsb)
         2'b00:   byte_lane = rdata[7:0];
         2'b01:   byte_lane = rdata[15:8];
         2'b10:   byte_lane = rdata[23:16];
         default: byte_lane = rdata[31:24];
      endcase
      half_lane = addr_lsb[1] ? rdata[31:16] : rdata[15:0];
   end

   // Extension to 32 bits; words pass through untouched.
   always_comb begin
      sign_bit = 1'b0;
      data_out = rdata;
      case (size)
         SIZE_BYTE: begin
            sign_bit = byte_lane[7] & ~is_unsigned;
            data_out = {{24{sign_bit}}, byte_lane};
         end
         SIZE_HALF: begin
            sign_bit = half_lane[15] & ~is_unsigned;
            data_out = {{16{sign_bit}}, half_lane};
         end
         default: begin
            sign_bit = 1'b0;
            data_out = rdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// MEM stage of the pipeline. Turns the load/store in the EX/MEM slot into a
// request/acknowledge transaction on the data-memory port, stalls the front
// of the pipeline while the transaction is outstanding, formats load data
// for MEM/WB and raises a bus error if the memory never answers.
//
// Parameter:
//   MAX_WAIT  BUSY cycles waited for dmem_ack before a bus error (1..255)
//
// Optional feature macro:
//   MEM_ALIGN_CHECK_EN  when defined, misaligned halves/words are rejected
//                       with align_err_out instead of being issued
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   valid_in                         EX/MEM slot holds a real instruction
//   ALU_result_in, store_data_in     address / ALU result, store data
//   mem_read_in, mem_write_in        load / store request
//   size_in, unsigned_in             access size, zero-extend loads
//   wb_*_in                          writeback controls from EX/MEM
//   ALU_result_out, mem_data_out     to MEM/WB
//   wb_*_out                         writeback controls to MEM/WB
//   stall_out                        freezes PC, IF/ID, ID/EX, EX/MEM
//   dmem_req/we/addr/wdata/be        data-memory request side
//   dmem_ack, dmem_rdata             data-memory response side
//   bus_err_out, align_err_out       one-cycle error pulses
// ---------------------------------------------------------------------------
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [31:0] ALU_result_in,
   input  logic [31:0] store_data_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic [1:0]  size_in,
   input  logic        unsigned_in,
   input  logic        wb_write_en_in,
   input  logic        wb_addr_sel_in,
   input  logic        wb_data_sel_in,
   input  logic [4:0]  wb_addr1_in,
   input  logic [4:0]  wb_addr2_in,
   output logic [31:0] ALU_result_out,
   output logic [31:0] mem_data_out,
   output logic        wb_write_en_out,
   output logic        wb_addr_sel_out,
   output logic        wb_data_sel_out,
   output logic [4:0]  wb_addr1_out,
   output logic [4:0]  wb_addr2_out,
   output logic        stall_out,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        bus_err_out,
   output logic        align_err_out
);

   state_t      state;
   state_t      state_next;
   logic        req_q;
   logic        bus_err_q;
   logic [31:0] wait_cnt;

   logic        mem_op;
   logic        misaligned;
   logic        start_access;
   logic        timeout;
   logic        ack_done;
   logic [31:0] load_data;

   // A real load or store sits in the EX/MEM slot.
   assign mem_op = valid_in & (mem_read_in | mem_write_in);

   // Alignment screening. Without the check, misaligned accesses are
   // issued anyway and the lane logic simply ignores the offending bits.
`ifdef MEM_ALIGN_CHECK_EN
   always_comb begin
      misaligned = 1'b0;
      case (size_in)
         SIZE_BYTE: misaligned = 1'b0;
         SIZE_HALF: misaligned = ALU_result_in[0];
         default:   misaligned = |ALU_result_in[1:0];
      endcase
   end

   assign align_err_out = ~reset & (state == ST_IDLE) & mem_op & misaligned;
`else
   assign misaligned    = 1'b0;
   assign align_err_out = 1'b0;
`endif

   assign start_access = mem_op & ~misaligned;

   // The wait counter holds the number of BUSY cycles already spent, so the
   // MAX_WAIT-th BUSY cycle without an ack is the last one. An ack in that
   // same cycle takes priority over the timeout.
   assign timeout  = (state == ST_BUSY) & ~dmem_ack
                   & (wait_cnt == 32'(MAX_WAIT - 1));
   assign ack_done = (state == ST_BUSY) & dmem_ack;

   // State register plus the registered request, wait counter and bus
   // error pulse. Reset wins even in the middle of an access.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         req_q     <= 1'b0;
         wait_cnt  <= 32'd0;
         bus_err_q <= 1'b0;
      end else begin
         state     <= state_next;
         req_q     <= (state_next == ST_BUSY);
         bus_err_q <= timeout;
         if (state == ST_IDLE && state_next == ST_BUSY) begin
            wait_cnt <= 32'd0;
         end else if (state == ST_BUSY && state_next == ST_BUSY) begin
            wait_cnt <= wait_cnt + 32'd1;
         end
      end
   end

   // Next-state logic: leave IDLE on an issuable access, leave BUSY on an
   // ack or when the wait budget runs out. Acks seen in IDLE are ignored.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start_access) begin
               state_next = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (dmem_ack || timeout) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   load_formatter u_load_formatter (
      .rdata       (dmem_rdata),
      .addr_lsb    (ALU_result_in[1:0]),
      .size        (size_in),
      .is_unsigned (unsigned_in),
      .data_out    (load_data)
   );

   // Output logic. The stall covers the issue cycle and every BUSY cycle up
   // to, but not including, the ack or timeout cycle. MEM/WB gets a bubble
   // whenever the slot is held back, timed out or rejected as misaligned.
   always_comb begin
      stall_out    = 1'b0;
      mem_data_out = 32'd0;
      if (!reset) begin
         case (state)
            ST_IDLE: stall_out = start_access;
            ST_BUSY: stall_out = ~dmem_ack & ~timeout;
            default: stall_out = 1'b0;
         endcase
         if (ack_done) begin
            mem_data_out = load_data;
         end
      end
      wb_write_en_out = wb_write_en_in & ~stall_out & ~(timeout & ~reset)
                      & ~align_err_out;
   end

   assign bus_err_out     = bus_err_q & ~reset;
   assign dmem_req        = req_q;

   // Request fields come straight from the frozen EX/MEM slot.
   assign dmem_we         = mem_write_in;
   assign dmem_addr       = {ALU_result_in[31:2], 2'b00};
   assign dmem_be         = store_byte_enable(size_in, ALU_result_in[1:0]);
   assign dmem_wdata      = store_lanes(size_in, store_data_in);

   assign ALU_result_out  = ALU_result_in;
   assign wb_addr_sel_out = wb_addr_sel_in;
   assign wb_data_sel_out = wb_data_sel_in;
   assign wb_addr1_out    = wb_addr1_in;
   assign wb_addr2_out    = wb_addr2_in;

endmodule
